// File: rtl/soc_hw_port_pkg.sv
// Shared types and register-map helpers for the soc_hw_port_bank output PIO.
// Offsets are functions of the channel count so the map tracks NUM_CH.
package soc_hw_port_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } chan_state_t;

    // STATUS field bases, in units of NUM_CH bits
    localparam int STAT_BUSY_BASE = 0;
    localparam int STAT_DONE_BASE = 1;
    localparam int STAT_ERR_BASE  = 2;

    function automatic int OFF_CTRL(input int n);
        return n;
    endfunction

    function automatic int OFF_STATUS(input int n);
        return n + 1;
    endfunction

    function automatic int OFF_MASK(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/soc_hw_port_chan.sv
// One output channel: data register, IDLE/VALID handshake FSM and the
// sticky done/err bits (set has priority over write-1-to-clear).
module soc_hw_port_chan
    import soc_hw_port_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_wr,
    input  logic              start,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_done,
    input  logic              clr_err,
    input  logic              hw_ack,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    chan_state_t state, state_nxt;
    logic        set_done;
    logic        set_err;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = VALID;
            VALID:   if (hw_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Start and data writes are judged against the current state, so a start
    // landing on the ack edge still counts as "while busy".
    assign set_done = (state == VALID) && hw_ack;
    assign set_err  = (state == VALID) && (start || data_wr);
    assign busy     = (state == VALID);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            data  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (data_wr && (state == IDLE))
                data <= wdata;
            done <= set_done || (done && !clr_done);
            err  <= set_err  || (err  && !clr_err);
        end
    end

endmodule

// File: rtl/soc_hw_port_bank.sv
// Multi-channel Avalon-MM output PIO with start/ack handshake per channel.
// Optional interrupt logic is enabled by defining SOC_HW_PORT_IRQ_EN.
module soc_hw_port_bank
    import soc_hw_port_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [DATA_W-1:0]        writedata,
    output logic [DATA_W-1:0]        readdata,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        hw_ack,
    output logic                     irq
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(OFF_CTRL(NUM_CH));
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(OFF_STATUS(NUM_CH));
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(OFF_MASK(NUM_CH));

    logic              wr;
    logic [DATA_W-1:0] chan_data [NUM_CH];
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] err;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] mask_rd;

    assign wr = chipselect & ~write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        soc_hw_port_chan #(.DATA_W(DATA_W)) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .data_wr  (wr && (address == ADDR_W'(g))),
            .start    (wr && (address == A_CTRL) && writedata[g]),
            .wdata    (writedata),
            .clr_done (wr && (address == A_STATUS) && writedata[STAT_DONE_BASE*NUM_CH + g]),
            .clr_err  (wr && (address == A_STATUS) && writedata[STAT_ERR_BASE*NUM_CH + g]),
            .hw_ack   (hw_ack[g]),
            .data     (chan_data[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .err      (err[g])
        );
        assign out_port[g*DATA_W +: DATA_W] = chan_data[g];
    end

    assign out_valid = busy;

    always_comb begin
        status = '0;
        status[STAT_BUSY_BASE*NUM_CH +: NUM_CH] = busy;
        status[STAT_DONE_BASE*NUM_CH +: NUM_CH] = done;
        status[STAT_ERR_BASE*NUM_CH  +: NUM_CH] = err;
    end

`ifdef SOC_HW_PORT_IRQ_EN
    logic [NUM_CH-1:0] irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && (address == A_MASK))
                irq_mask <= writedata[NUM_CH-1:0];
            irq <= |(done & irq_mask);
        end
    end

    assign mask_rd = DATA_W'(irq_mask);
`else
    assign irq     = 1'b0;
    assign mask_rd = '0;
`endif

    // Zero-latency read: pure function of address, chipselect not involved.
    always_comb begin
        readdata = '0;
        if (address == A_STATUS) begin
            readdata = status;
        end else if (address == A_MASK) begin
            readdata = mask_rd;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (address == ADDR_W'(i))
                    readdata = chan_data[i];
        end
    end

endmodule

// File: tb/tb_soc_hw_port_bank.sv
// Scoreboard bench for soc_hw_port_bank; expectations are queued as stimulus
// is applied and matched against observations in order.
module tb_soc_hw_port_bank;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 3;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [ADDR_W-1:0]        address = '0;
    logic                     chipselect = 1'b0;
    logic                     write_n = 1'b1;
    logic [DATA_W-1:0]        writedata = '0;
    logic [DATA_W-1:0]        readdata;
    logic [NUM_CH*DATA_W-1:0] out_port;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        hw_ack = '0;
    logic                     irq;

    always #5 clk = ~clk;

    soc_hw_port_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .hw_ack     (hw_ack),
        .irq        (irq)
    );

    typedef struct {
        string             name;
        logic [DATA_W-1:0] val;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    int                vectors = 0;
    int                miscompares = 0;

`ifdef SOC_HW_PORT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    task automatic expect_val(input string name, input logic [DATA_W-1:0] v);
        exp_q.push_back('{name, v});
    endtask

    task automatic observe(input logic [DATA_W-1:0] v);
        obs_q.push_back(v);
    endtask

    task automatic observe_reg(input logic [ADDR_W-1:0] a);
        address = a;
        #1;
        obs_q.push_back(readdata);
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic ack_pulse(input logic [NUM_CH-1:0] m);
        hw_ack = m;
        @(posedge clk);
        #1;
        hw_ack = '0;
    endtask

    task automatic test_reset;
        #2;
        expect_val("rst_out_valid", 0); observe(DATA_W'(out_valid));
        expect_val("rst_irq", 0);       observe(DATA_W'(irq));
        expect_val("rst_status", 0);    observe_reg(3'd5);
        expect_val("rst_data2", 0);     observe_reg(3'd2);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    task automatic test_data_write;
        bus_write(3'd2, 32'hDEAD_BEEF);
        expect_val("out_port_ch2", 32'hDEAD_BEEF); observe(out_port[95:64]);
        expect_val("rd_data2", 32'hDEAD_BEEF);     observe_reg(3'd2);
        expect_val("rd_addr7", 0);                 observe_reg(3'd7);
        expect_val("rd_ctrl", 0);                  observe_reg(3'd4);
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    task automatic test_start_ack;
        bus_write(3'd4, 32'h5);
        expect_val("start_valid", 32'h5);  observe(DATA_W'(out_valid));
        expect_val("start_status", 32'h5); observe_reg(3'd5);
        ack_pulse(4'b0001);
        expect_val("ack_valid", 32'h4);    observe(DATA_W'(out_valid));
        expect_val("ack_status", 32'h14);  observe_reg(3'd5);
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    task automatic test_busy_write;
        bus_write(3'd4, 32'h2);
        expect_val("ch1_valid", 32'h6);       observe(DATA_W'(out_valid));
        bus_write(3'd1, 32'h1234);
        expect_val("busy_data1", 0);          observe_reg(3'd1);
        expect_val("busy_port1", 0);          observe(out_port[63:32]);
        expect_val("busy_err_status", 32'h216); observe_reg(3'd5);
        bus_write(3'd5, 32'h200);
        expect_val("w1c_err_status", 32'h016);  observe_reg(3'd5);
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    task automatic test_same_cycle;
        bus_write(3'd4, 32'h8);
        expect_val("ch3_status", 32'h1E);     observe_reg(3'd5);
        hw_ack = 4'b1000;
        bus_write(3'd4, 32'h8);
        hw_ack = '0;
        expect_val("ack_start_valid", 32'h6);   observe(DATA_W'(out_valid));
        expect_val("ack_start_status", 32'h896); observe_reg(3'd5);
        // done[1] set and W1C of done[1] on the same edge
        hw_ack = 4'b0010;
        bus_write(3'd5, 32'h20);
        hw_ack = '0;
        expect_val("set_wins_status", 32'h8B4); observe_reg(3'd5);
        expect_val("set_wins_valid", 32'h4);    observe(DATA_W'(out_valid));
        bus_write(3'd5, 32'h10);
        expect_val("clr_done0", 32'h8A4);       observe_reg(3'd5);
        ack_pulse(4'b0001);
        expect_val("idle_ack_status", 32'h8A4); observe_reg(3'd5);
        expect_val("idle_ack_valid", 32'h4);    observe(DATA_W'(out_valid));
        ack_pulse(4'b0100);
        bus_write(3'd5, 32'hFF0);
        expect_val("all_clear", 0);             observe_reg(3'd5);
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    task automatic test_irq;
        bus_write(3'd6, 32'h1);
        expect_val("mask_rd", IRQ_ON ? 32'h1 : 32'h0); observe_reg(3'd6);
        bus_write(3'd4, 32'h1);
        ack_pulse(4'b0001);
        expect_val("irq_done_edge", 0);          observe(DATA_W'(irq));
        expect_val("irq_done_status", 32'h10);   observe_reg(3'd5);
        @(posedge clk);
        #1;
        expect_val("irq_assert", DATA_W'(IRQ_ON)); observe(DATA_W'(irq));
        bus_write(3'd5, 32'h10);
        expect_val("irq_clr_edge", DATA_W'(IRQ_ON)); observe(DATA_W'(irq));
        @(posedge clk);
        #1;
        expect_val("irq_deassert", 0);           observe(DATA_W'(irq));
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    task automatic test_async_reset;
        bus_write(3'd0, 32'hA5A5_0001);
        bus_write(3'd6, 32'h3);
        bus_write(3'd4, 32'h3);
        ack_pulse(4'b0010);
        @(posedge clk);
        #1;
        expect_val("pre_rst_valid", 32'h1);        observe(DATA_W'(out_valid));
        expect_val("pre_rst_irq", DATA_W'(IRQ_ON)); observe(DATA_W'(irq));
        expect_val("pre_rst_data0", 32'hA5A5_0001); observe_reg(3'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        expect_val("arst_valid", 0);  observe(DATA_W'(out_valid));
        expect_val("arst_port0", 0);  observe(out_port[31:0]);
        expect_val("arst_irq", 0);    observe(DATA_W'(irq));
        expect_val("arst_status", 0); observe_reg(3'd5);
        expect_val("arst_data0", 0);  observe_reg(3'd0);
        expect_val("arst_mask", 0);   observe_reg(3'd6);
        @(negedge clk);
        reset_n = 1'b1;
        while (exp_q.size() > 0) begin
            exp_t e; logic [DATA_W-1:0] o;
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL %s: no observation, expected %h", e.name, e.val); end
            else begin o = obs_q.pop_front(); if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end end
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_start_ack();
        test_busy_write();
        test_same_cycle();
        test_irq();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
